// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
//
// Purpose: bundles every request, response and SRAM signal of the
// fetch/data SRAM port arbiter so the arbiter and its environment connect
// through one port.
//
// Signal groups:
//   fetch_req_valid/ready/addr, fetch_flush  instruction read requests
//   fetch_rsp_valid/data                      instruction responses
//   data_req_valid/ready/addr/write/wdata/wstrb  load/store requests
//   data_rsp_valid/data                       load responses
//   sram_enable/write_enable/address/write_data/byte_enable, sram_read_data
//                                              single-port SRAM side
//
// Handshake: a request transfers in the cycle where valid && ready. ready is
// a combinational grant for that same cycle. While valid && !ready the
// requester holds all request fields stable. Responses (*_rsp_valid) have no
// ready; the requester must take them in the cycle they appear.
//
// Modports:
//   slave  - the arbiter
//   master - the requesters plus the SRAM (the environment)
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      fetch_req_valid;
   logic                      fetch_req_ready;
   logic [ADDR_WIDTH-1:0]     fetch_req_addr;
   logic                      fetch_flush;
   logic                      fetch_rsp_valid;
   logic [DATA_WIDTH-1:0]     fetch_rsp_data;

   logic                      data_req_valid;
   logic                      data_req_ready;
   logic [ADDR_WIDTH-1:0]     data_req_addr;
   logic                      data_req_write;
   logic [DATA_WIDTH-1:0]     data_req_wdata;
   logic [DATA_WIDTH/8-1:0]   data_req_wstrb;
   logic                      data_rsp_valid;
   logic [DATA_WIDTH-1:0]     data_rsp_data;

   logic                      sram_enable;
   logic                      sram_write_enable;
   logic [ADDR_WIDTH-3:0]     sram_address;
   logic [DATA_WIDTH-1:0]     sram_write_data;
   logic [DATA_WIDTH/8-1:0]   sram_byte_enable;
   logic [DATA_WIDTH-1:0]     sram_read_data;

   modport slave (
      input  fetch_req_valid, fetch_req_addr, fetch_flush,
      input  data_req_valid, data_req_addr, data_req_write,
      input  data_req_wdata, data_req_wstrb,
      input  sram_read_data,
      output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
      output data_req_ready, data_rsp_valid, data_rsp_data,
      output sram_enable, sram_write_enable, sram_address,
      output sram_write_data, sram_byte_enable
   );

   modport master (
      output fetch_req_valid, fetch_req_addr, fetch_flush,
      output data_req_valid, data_req_addr, data_req_write,
      output data_req_wdata, data_req_wstrb,
      output sram_read_data,
      input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
      input  data_req_ready, data_rsp_valid, data_rsp_data,
      input  sram_enable, sram_write_enable, sram_address,
      input  sram_write_data, sram_byte_enable
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Purpose: shares one single-port SRAM with 1-cycle read latency between
// the fetch stage (instruction reads) and the memory stage (loads/stores).
// At most one request is granted per cycle. The data port wins by default;
// a saturating streak counter hands the slot to a waiting fetch after
// MAX_DATA_STREAK consecutive data wins (0 disables this, giving strict data
// priority). Read responses are steered back to the requester that issued
// them; fetch_flush drops an in-flight instruction response.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-low reset
//   bus  - sram_port_arbiter_if.slave carrying both request ports, both
//          response ports and the SRAM interface
//
// Parameters:
//   ADDR_WIDTH       byte-address width of both request ports
//   DATA_WIDTH       SRAM word width (multiple of 8)
//   MAX_DATA_STREAK  data grants allowed in a row while fetch waits
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   sram_port_arbiter_if.slave        bus
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   // A zero streak limit still needs a 1-bit counter to keep the code regular.
   localparam int STREAK_W = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
   localparam bit FAIRNESS_ON = (MAX_DATA_STREAK != 0);

   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   // Registered state
   logic                rsp_pending_q, rsp_pending_d;
   owner_e              rsp_owner_q,   rsp_owner_d;
   logic [STREAK_W-1:0] streak_q,      streak_d;

   // Arbitration terms
   logic fetch_eligible;
   logic fetch_forced;
   logic grant_data;
   logic grant_fetch;
   logic grant_read;

   // Word addressing drops the byte offset; these bits are intentionally unused.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.fetch_req_addr[1:0], bus.data_req_addr[1:0]};

   // ------------------------------------------------------------------------
   // Grant decision. Grants are gated with rst so that nothing is issued to
   // the SRAM while reset is asserted, even though the decision itself is
   // combinational.
   // ------------------------------------------------------------------------
   always_comb begin
      fetch_eligible = bus.fetch_req_valid && !bus.fetch_flush;
      // Fetch takes the slot once data has won STREAK_MAX times in a row.
      fetch_forced   = FAIRNESS_ON && fetch_eligible && (streak_q >= STREAK_MAX);
      grant_data     = rst && bus.data_req_valid && !fetch_forced;
      grant_fetch    = rst && fetch_eligible && !grant_data;
      grant_read     = grant_fetch || (grant_data && !bus.data_req_write);
   end

   assign bus.fetch_req_ready = grant_fetch;
   assign bus.data_req_ready  = grant_data;

   // ------------------------------------------------------------------------
   // SRAM drive from the granted request; all zero when idle.
   // ------------------------------------------------------------------------
   always_comb begin
      bus.sram_enable       = 1'b0;
      bus.sram_write_enable = 1'b0;
      bus.sram_address      = '0;
      bus.sram_write_data   = '0;
      bus.sram_byte_enable  = '0;
      if (grant_data) begin
         bus.sram_enable  = 1'b1;
         bus.sram_address = bus.data_req_addr[ADDR_WIDTH-1:2];
         if (bus.data_req_write) begin
            bus.sram_write_enable = 1'b1;
            bus.sram_write_data   = bus.data_req_wdata;
            bus.sram_byte_enable  = bus.data_req_wstrb;
         end else begin
            bus.sram_byte_enable  = {BE_WIDTH{1'b1}};
         end
      end else if (grant_fetch) begin
         bus.sram_enable      = 1'b1;
         bus.sram_address     = bus.fetch_req_addr[ADDR_WIDTH-1:2];
         bus.sram_byte_enable = {BE_WIDTH{1'b1}};
      end
   end

   // ------------------------------------------------------------------------
   // Next-state: response tracking and streak counter.
   // ------------------------------------------------------------------------
   always_comb begin
      rsp_pending_d = grant_read;
      rsp_owner_d   = rsp_owner_q;
      if (grant_data && !bus.data_req_write) begin
         rsp_owner_d = OWNER_DATA;
      end else if (grant_fetch) begin
         rsp_owner_d = OWNER_FETCH;
      end

      // The streak only measures data wins that made a live fetch wait.
      streak_d = streak_q;
      if (grant_fetch || !fetch_eligible) begin
         streak_d = '0;
      end else if (grant_data && (streak_q < STREAK_MAX)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_pending_q <= 1'b0;
         rsp_owner_q   <= OWNER_FETCH;
         streak_q      <= '0;
      end else begin
         rsp_pending_q <= rsp_pending_d;
         rsp_owner_q   <= rsp_owner_d;
         streak_q      <= streak_d;
      end
   end

   // ------------------------------------------------------------------------
   // Response steering. The flush masks only the fetch response; a data
   // response in the same cycle still goes out.
   // ------------------------------------------------------------------------
   always_comb begin
      bus.fetch_rsp_valid = rsp_pending_q && (rsp_owner_q == OWNER_FETCH) && !bus.fetch_flush;
      bus.data_rsp_valid  = rsp_pending_q && (rsp_owner_q == OWNER_DATA);
      bus.fetch_rsp_data  = bus.fetch_rsp_valid ? bus.sram_read_data : '0;
      bus.data_rsp_data   = bus.data_rsp_valid  ? bus.sram_read_data : '0;
   end

endmodule
